// File: rtl/op_sequencer_pkg.sv
// Shared encodings for the operation sequencer: op codes, FSM states, default width.
package op_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Operation select encodings
    typedef enum logic [1:0] {
        OP_INV = 2'b00,
        OP_CNT = 2'b01,
        OP_MUL = 2'b10,
        OP_PAR = 2'b11
    } op_e;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        MUL  = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/seq_mul_core.sv
// Shift-and-add unsigned multiplier: one multiplier bit per step, LSB first.
// `product` is the accumulator value after the current step, so the caller can
// capture the final result on the same edge as the last step.
module seq_mul_core #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);

    localparam int QW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    logic [QW-1:0]    acc_q, acc_d;
    logic [QW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    count_q, count_d;
    logic [QW-1:0]    acc_sum;

    // Partial-sum for the current multiplier bit and the last-iteration flag
    always_comb begin
        acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
        last    = (count_q == CW'(WIDTH - 1));
        product = acc_sum;
    end

    // Next-state of the iteration registers: load clears, step shifts and accumulates
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        if (load) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, b};
            mplier_d = a;
            count_d  = '0;
        end else if (step) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
        end
    end

    // Iteration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/op_sequencer.sv
// Operation sequencer: accepts one op at a time (invert, counter snapshot,
// multiply, parity), produces a registered result with a one-cycle done pulse.
// Handshake: start is sampled only in IDLE; busy is high in every other state;
// done is high for exactly the one cycle in DONE, when q holds the new result.
module op_sequencer
    import op_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               hold,
    output logic [2*WIDTH-1:0] q,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state
);

    localparam int QW = 2 * WIDTH;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [QW-1:0]    q_q, q_d;
    logic             done_q, done_d;
    logic [QW-1:0]    cnt_q, cnt_d;

    logic             mul_load;
    logic             mul_step;
    logic [QW-1:0]    mul_product;
    logic             mul_last;

    seq_mul_core #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load),
        .step    (mul_step),
        .a       (A),
        .b       (B),
        .product (mul_product),
        .last    (mul_last)
    );

    // Free-running counter, frozen while hold is high, wraps naturally
    always_comb begin
        cnt_d = hold ? cnt_q : cnt_q + QW'(1);
    end

    // FSM next-state, operand latch and result register update
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        q_d      = q_q;
        done_d   = 1'b0;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = op_e'(op);
                    a_d  = A;
                    b_d  = B;
                    if (op_e'(op) == OP_MUL) begin
                        mul_load = 1'b1;
                        state_d  = MUL;
                    end else begin
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                case (op_q)
                    OP_INV:  q_d = {~a_q, ~b_q};
                    OP_CNT:  q_d = cnt_q;
                    OP_PAR:  q_d = {{(QW-1){1'b0}}, ^b_q};
                    default: q_d = q_q;
                endcase
                done_d  = 1'b1;
                state_d = DONE;
            end
            MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    q_d     = mul_product;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand, result and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_INV;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output mapping
    always_comb begin
        q         = q_q;
        done      = done_q;
        busy      = (state_q != IDLE);
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_op_sequencer.sv
// Testbench for op_sequencer: vector table through a scoreboard, plus
// hand-written sequences for latency, busy rejection, counter and reset abort.
module tb_op_sequencer;
  import op_sequencer_pkg::*;

  localparam int W  = 8;
  localparam int QW = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  b_in = '0;
  logic          hold = 1'b0;
  logic [QW-1:0] q;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  op_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .A         (a_in),
    .B         (b_in),
    .hold      (hold),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [QW-1:0] exp_q[$];

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [QW-1:0] exp;
  } vec_t;

  vec_t vecs[14];

  // done pulse counter
  always @(negedge clk) if (done) done_cnt = done_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one start pulse; returns just after the accept edge
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input logic [QW-1:0] want);
    op = o; a_in = a; b_in = b; start = 1'b1;
    tick();
    start = 1'b0;
    if (push) exp_q.push_back(want);
  endtask

  // wait for done (bounded), pop expected result and compare
  task automatic wait_done(input string name);
    int n = 0;
    logic [QW-1:0] e;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_timeout: got=no_done want=done", name);
    end else if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s_unexpected_done: got=%0h want=none", name, q);
    end else begin
      e = exp_q.pop_front();
      check(name, {16'h0, q}, {16'h0, e});
    end
  endtask

  initial begin
    int d0;
    int busy_cycles;

    // reset state, start ignored while reset held
    rst = 1'b1; hold = 1'b0; start = 1'b1; op = 2'b10;
    repeat (3) tick();
    check("rst_q", {16'h0, q}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, {30'h0, IDLE});
    start = 1'b0;
    rst = 1'b0;

    // counter snapshot after 5 free-running edges
    repeat (5) tick();
    hold = 1'b1;
    issue(2'b01, 8'h00, 8'h00, 1, 16'h0005);
    wait_done("cnt_5");
    tick();
    // run to 0xFFFF then wrap
    hold = 1'b0;
    repeat (16'hFFFA) @(posedge clk);
    #1 hold = 1'b1;
    issue(2'b01, 8'h00, 8'h00, 1, 16'hFFFF);
    wait_done("cnt_ffff");
    tick();
    hold = 1'b0;
    tick();
    hold = 1'b1;
    issue(2'b01, 8'h00, 8'h00, 1, 16'h0000);
    wait_done("cnt_wrap");
    tick();
    hold = 1'b0;

    // vector table
    vecs[0]  = '{2'b00, 8'h0F, 8'hF0, 16'hF00F};
    vecs[1]  = '{2'b11, 8'h00, 8'h07, 16'h0001};
    vecs[2]  = '{2'b11, 8'hAA, 8'h03, 16'h0000};
    vecs[3]  = '{2'b10, 8'hFF, 8'hFF, 16'hFE01};
    vecs[4]  = '{2'b10, 8'h00, 8'hFF, 16'h0000};
    vecs[5]  = '{2'b10, 8'h03, 8'h04, 16'h000C};
    vecs[6]  = '{2'b10, 8'h80, 8'h02, 16'h0100};
    vecs[7]  = '{2'b00, 8'h00, 8'h00, 16'hFFFF};
    vecs[8]  = '{2'b11, 8'h00, 8'hFF, 16'h0000};
    vecs[9]  = '{2'b11, 8'h00, 8'h80, 16'h0001};
    vecs[10] = '{2'b00, 8'hA5, 8'h3C, 16'h5AC3};
    for (int i = 11; i < 14; i++) begin
      vecs[i].op = 2'b10;
      vecs[i].a = 8'($urandom_range(1, 255));
      vecs[i].b = 8'($urandom_range(1, 255));
      vecs[i].exp = {8'h00, vecs[i].a} * {8'h00, vecs[i].b};
    end
    for (int i = 0; i < 14; i++) begin
      logic [QW-1:0] held;
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1, vecs[i].exp);
      wait_done($sformatf("vec%0d", i));
      held = q;
      tick();
      check($sformatf("vec%0d_done_low", i), {31'h0, done}, 32'h0);
      check($sformatf("vec%0d_idle", i), {31'h0, busy}, 32'h0);
      check($sformatf("vec%0d_q_held", i), {16'h0, q}, {16'h0, vecs[i].exp});
      if (held !== vecs[i].exp) ; // value compared above via scoreboard
    end

    // multiply latency: done only at E+8, busy for 9 cycles
    d0 = done_cnt;
    issue(2'b10, 8'hFF, 8'hFF, 0, '0);
    busy_cycles = busy ? 1 : 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (busy) busy_cycles++;
      check($sformatf("lat_done_k%0d", k), {31'h0, done}, {31'h0, (k == 8)});
      if (k == 8) check("lat_q", {16'h0, q}, 32'hFE01);
    end
    check("lat_busy_cycles", busy_cycles, 9);
    check("lat_done_count", done_cnt - d0, 1);

    // busy rejection: op 00 pulsed at E+3 of a multiply
    d0 = done_cnt;
    issue(2'b10, 8'h03, 8'h04, 1, 16'h000C);
    tick(); tick();
    op = 2'b00; a_in = 8'h11; b_in = 8'h22; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("rej_q");
    repeat (5) tick();
    check("rej_single_done", done_cnt - d0, 1);
    check("rej_q_kept", {16'h0, q}, 32'h000C);
    check("rej_idle", {31'h0, busy}, 32'h0);

    // start during DONE is ignored
    d0 = done_cnt;
    issue(2'b00, 8'h12, 8'h34, 1, 16'hEDCB);
    wait_done("done_ign_q");
    op = 2'b11; b_in = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    check("done_ign_idle", {31'h0, busy}, 32'h0);
    repeat (3) tick();
    check("done_ign_count", done_cnt - d0, 1);
    check("done_ign_q_kept", {16'h0, q}, 32'hEDCB);

    // reset abort at E+4 of a multiply
    d0 = done_cnt;
    issue(2'b10, 8'h55, 8'h33, 1, 16'h10EF);
    repeat (3) tick();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    exp_q.delete();
    check("abort_q", {16'h0, q}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    start = 1'b1; op = 2'b10;
    repeat (2) tick();
    check("abort_start_ignored", {31'h0, busy}, 32'h0);
    start = 1'b0;
    rst = 1'b0;
    repeat (12) tick();
    check("abort_no_done", done_cnt - d0, 0);
    issue(2'b11, 8'h00, 8'h01, 1, 16'h0001);
    wait_done("abort_fresh_par");
    tick();

    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL leftover_expected: got=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
